// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_add_pkg;

    // Controller phases: waiting for an operand pair, shifting bits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/sum width.
    localparam int SERIAL_ADD_W_DEF = 8;

    // Bit counter width: enough to count W bit positions, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder shared by the serial controller; S = A^B^Ci, Co = majority.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no storage and no handshake.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic Co,
    output logic S
);

    // Sum and carry-out of a single bit position.
    always_comb begin
        S  = A ^ B ^ Ci;
        Co = (A & B) | (Ci & (A ^ B));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: feeds one full_adder LSB-first over W cycles ({cout,sum} = a+b+cin).
// Latency: out_valid rises W cycles after the accept edge; W+2 cycles minimum per operation.
// Backpressure: DONE holds sum/cout stable while out_ready=0; in_ready low until the result is taken.
// Build option: SERIAL_ADD_SUB_EN adds a 'sub' input selecting a - b (cout=1 means no borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = SERIAL_ADD_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_s;
    logic               fa_co;
    logic               accept;
    logic               last_bit;
    logic [W-1:0]       b_load;
    logic               carry_load;

    // The single shared bit-slice adder always sees the current LSBs and running carry.
    full_adder u_fa (
        .A  (a_sh_q[0]),
        .B  (b_sh_q[0]),
        .Ci (carry_q),
        .Co (fa_co),
        .S  (fa_s)
    );

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_bit = (cnt_q == CNT_LAST);

    // Operand conditioning at load time: subtraction is a + ~b + 1.
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load     = b;
        carry_load = cin;
    end
`endif

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, W shift cycles in RUN, wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, no path from in_valid/out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per RUN cycle, otherwise hold.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b_load;
            carry_d = carry_load;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d           = a_sh_q >> 1;
            b_sh_d           = b_sh_q >> 1;
            // New sum bit enters at the MSB so after W shifts bit 0 sits at sum_sh[0].
            sum_sh_d         = sum_sh_q >> 1;
            sum_sh_d[W-1]    = fa_s;
            carry_d          = fa_co;
            cnt_d            = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; sum and carry double as the held result outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sum  = sum_sh_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised scoreboard bench for serial_add_ctrl at W=8 and W=1.
// Expected results come from plain integer arithmetic on the operands.
// Monitors pop expected results on each output handshake and check out_valid latency.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, cout, busy, cin;
    logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif

    logic in_valid_1, in_ready_1, out_valid_1, out_ready_1, cout_1, busy_1, cin_1;
    logic [0:0] a_1, b_1, sum_1;
`ifdef SERIAL_ADD_SUB_EN
    logic sub_1;
`endif

    serial_add_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_add_ctrl #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_1),
`endif
        .a         (a_1),
        .b         (b_1),
        .cin       (cin_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .sum       (sum_1),
        .cout      (cout_1),
        .busy      (busy_1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    typedef struct { logic [W:0] res; int acc; } exp8_t;
    typedef struct { logic [1:0] res; int acc; } exp1_t;
    exp8_t q8[$];
    exp1_t q1[$];

    // Reference: {cout,sum} = a + b + cin, or a - b + 2^W when subtracting.
    function automatic logic [W:0] model8(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
        longint r;
        if (s) r = longint'(x) - longint'(y) + (longint'(1) << W);
        else   r = longint'(x) + longint'(y) + longint'(c);
        return r[W:0];
    endfunction

    // Monitor W=8: latency on out_valid rise, result on output handshake.
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        exp8_t e;
        if (!rst) begin
            if (out_valid && !ov_prev) begin
                if (q8.size() == 0) check("unexpected_out_valid8", 1, 0);
                else check("latency8", 64'(cyc - q8[0].acc), 64'(W));
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) check("unexpected_result8", 1, 0);
                else begin
                    e = q8.pop_front();
                    check("result8", {cout, sum}, 64'(e.res));
                end
            end
        end
        ov_prev = rst ? 1'b0 : out_valid;
    end

    // Monitor W=1.
    logic ov1_prev = 1'b0;
    always @(negedge clk) begin
        exp1_t e;
        if (!rst) begin
            if (out_valid_1 && !ov1_prev) begin
                if (q1.size() == 0) check("unexpected_out_valid1", 1, 0);
                else check("latency1", 64'(cyc - q1[0].acc), 64'd1);
            end
            if (out_valid_1 && out_ready_1) begin
                if (q1.size() == 0) check("unexpected_result1", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("result1", {cout_1, sum_1}, 64'(e.res));
                end
            end
        end
        ov1_prev = rst ? 1'b0 : out_valid_1;
    end

    // Issue one W=8 operation and drain it; bp=1 runs the back-pressure scenario.
    task automatic op8(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic cc, input logic ss, input bit bp);
        exp8_t e;
        int t;
        bit hs;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1; a = aa; b = bb; cin = cc;
`ifdef SERIAL_ADD_SUB_EN
        sub = ss;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = model8(aa, bb, cc, ss);
        e.acc = cyc;
        q8.push_back(e);
        t = 0;
        if (bp) begin
            out_ready = 1'b0;
            while (!out_valid && t < 50) begin
                @(posedge clk); #1; t++;
            end
            for (int k = 0; k < 5; k++) begin
                in_valid = (k % 2 == 0);
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_hold", {cout, sum}, 64'(e.res));
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp_idle_ready", in_ready, 1);
            check("bp_idle_busy", busy, 0);
            @(posedge clk); #1;
            check("bp_no_second_op", busy, 0);
        end else begin
            hs = 1'b0;
            while (!hs && t < 100) begin
                out_ready = 1'($urandom);
                in_valid  = 1'($urandom);
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                hs = out_valid && out_ready;
                @(posedge clk); #1; t++;
                in_valid = 1'b0;
            end
            out_ready = 1'b0;
            if (!hs) check("handshake_timeout8", 0, 1);
        end
    endtask

    // Issue one W=1 operation and take the result after a random delay.
    task automatic op1(input logic aa, input logic bb, input logic cc);
        exp1_t e;
        int t;
        bit hs;
        in_valid_1 = 1'b1; a_1 = aa; b_1 = bb; cin_1 = cc;
        @(posedge clk); #1;
        in_valid_1 = 1'b0;
        e.res = 2'(aa) + 2'(bb) + 2'(cc);
        e.acc = cyc;
        q1.push_back(e);
        t = 0;
        hs = 1'b0;
        while (!hs && t < 20) begin
            out_ready_1 = 1'($urandom);
            hs = out_valid_1 && out_ready_1;
            @(posedge clk); #1; t++;
        end
        out_ready_1 = 1'b0;
        if (!hs) check("handshake_timeout1", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid_1 = 1'b0; out_ready_1 = 1'b0; a_1 = '0; b_1 = '0; cin_1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0; sub_1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready1", in_ready_1, 1);

        // Directed cases.
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        check("idle_keeps_sum", sum, 8'hFF);
        check("idle_keeps_cout", cout, 1);
        op8(8'hA5, 8'h0F, 1'b1, 1'b0, 1'b1);

        // Reset on the third RUN cycle discards the operation.
        in_valid = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        q8.delete();
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        op8(8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            op8(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        sub = 1'b0;
`endif

        // Randomised additions, including operand extremes.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 7 == 0) ra = '1;
            if (i % 5 == 0) rb = '1;
            op8(ra, rb, 1'($urandom), 1'b0, 1'b0);
        end

        // W=1: full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        repeat (3) @(posedge clk);
        #1;
        check("drained8", 64'(q8.size()), 0);
        check("drained1", 64'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
